// File: rtl/dds_pkg.sv
// dds_pkg: shared constants for the DDS phase accumulator slice.
//   MODE_*  : encodings of the 2-bit mode input
//   SEL_*   : register select values for the fph input
package dds_pkg;

   localparam logic [1:0] MODE_RUN   = 2'b00;
   localparam logic [1:0] MODE_HOLD  = 2'b01;
   localparam logic [1:0] MODE_READ  = 2'b10;
   localparam logic [1:0] MODE_WRITE = 2'b11;

   localparam logic SEL_FREQ  = 1'b0;
   localparam logic SEL_PHASE = 1'b1;

endpackage

// File: rtl/dds_word_bus.sv
// dds_word_bus: read-back mux and tri-state driver for the shared register bus.
// Ports:
//   mode  in     2  current operating mode; the bus is driven only in MODE_READ
//   fph   in     1  register select (SEL_FREQ / SEL_PHASE)
//   freq  in     M  frequency word register
//   poff  in     M  phase offset register
//   word  inout  M  driven with the selected register in MODE_READ, else high-Z
module dds_word_bus
   import dds_pkg::*;
#(
   parameter int unsigned M = 5
) (
   input  logic [1:0]   mode,
   input  logic         fph,
   input  logic [M-1:0] freq,
   input  logic [M-1:0] poff,
   inout  logic [M-1:0] word
);

   logic [M-1:0] rd_data;
   logic         rd_en;

   always_comb begin
      rd_data = (fph == SEL_PHASE) ? poff : freq;
      rd_en   = (mode == MODE_READ);
   end

   assign word = rd_en ? rd_data : {M{1'bz}};

endmodule

// File: rtl/dds_phase_accumulator.sv
// dds_phase_accumulator: DDS front end. An M-bit accumulator advances by a
// programmable frequency word each run cycle; a programmable phase offset is
// added combinationally and the top N bits of the sum form the phase output.
// Both registers share one bidirectional word bus for write and read-back.
// Ports:
//   clk    in     1  rising-edge clock
//   reset  in     1  synchronous, active-low reset (priority over mode)
//   mode   in     2  00 run, 01 hold, 10 read-back, 11 write
//   fph    in     1  register select: 0 frequency word, 1 phase offset
//   word   inout  M  write data in mode 11, driven by this block in mode 10
//   phase  out    N  top N bits of (acc + poff) mod 2^M
//   wrap   out    1  present only when PHASE_ACC_WRAP_EN is defined: registered
//                    one-cycle pulse after a run update that overflowed acc
// Configuration macro: PHASE_ACC_WRAP_EN (adds the wrap output).
module dds_phase_accumulator
   import dds_pkg::*;
#(
   parameter int unsigned M = 5,
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   mode,
   input  logic         fph,
   inout  logic [M-1:0] word,
   output logic [N-1:0] phase
`ifdef PHASE_ACC_WRAP_EN
   ,
   output logic         wrap
`endif
);

   logic [M-1:0] acc_q, acc_d;
   logic [M-1:0] freq_q, freq_d;
   logic [M-1:0] poff_q, poff_d;
   logic [M-1:0] acc_sum;

   always_comb begin
      acc_sum = acc_q + freq_q;  // carry discarded: modulo 2^M
      acc_d   = acc_q;
      freq_d  = freq_q;
      poff_d  = poff_q;
      unique case (mode)
         MODE_RUN: acc_d = acc_sum;
         MODE_WRITE: begin
            if (fph == SEL_PHASE) poff_d = word;
            else                  freq_d = word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q  <= '0;
         freq_q <= '0;
         poff_q <= '0;
      end else begin
         acc_q  <= acc_d;
         freq_q <= freq_d;
         poff_q <= poff_d;
      end
   end

   // The sum is self-determined at M bits, so the offset add also wraps mod 2^M.
   assign phase = N'((acc_q + poff_q) >> (M - N));

`ifdef PHASE_ACC_WRAP_EN
   logic wrap_q, wrap_d;

   // A modulo-2^M sum smaller than acc means the addition carried out.
   always_comb begin
      wrap_d = (mode == MODE_RUN) && (acc_sum < acc_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) wrap_q <= 1'b0;
      else        wrap_q <= wrap_d;
   end

   assign wrap = wrap_q;
`endif

   dds_word_bus #(
      .M(M)
   ) u_word_bus (
      .mode(mode),
      .fph (fph),
      .freq(freq_q),
      .poff(poff_q),
      .word(word)
   );

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// tb_dds_phase_accumulator: directed self-checking bench for the DDS phase
// accumulator at M=5, N=4. The word bus has a pull-up so an undriven bus
// reads back as all ones.
module tb_dds_phase_accumulator;

   localparam int unsigned M = 5;
   localparam int unsigned N = 4;

   localparam logic [1:0] RUN   = 2'b00;
   localparam logic [1:0] HOLD  = 2'b01;
   localparam logic [1:0] READ  = 2'b10;
   localparam logic [1:0] WRITE = 2'b11;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   mode;
   logic         fph;
   logic [N-1:0] phase;
   logic         drv_en;
   logic [M-1:0] drv_val;
   tri1  [M-1:0] word;
`ifdef PHASE_ACC_WRAP_EN
   logic         wrap;
`endif

   int checks = 0;
   int errors = 0;

   assign word = drv_en ? drv_val : {M{1'bz}};

   always #5 clk = ~clk;

   dds_phase_accumulator #(
      .M(M),
      .N(N)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .mode (mode),
      .fph  (fph),
      .word (word),
      .phase(phase)
`ifdef PHASE_ACC_WRAP_EN
      ,
      .wrap (wrap)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_wrap(input string tag, input logic exp);
`ifdef PHASE_ACC_WRAP_EN
      check_eq(tag, {31'd0, wrap}, {31'd0, exp});
`else
      if (exp === 1'bx) $display("unused wrap tag %s", tag);
`endif
   endtask

   // Sample 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic sel, input logic [M-1:0] val);
      mode    = WRITE;
      fph     = sel;
      drv_val = val;
      drv_en  = 1'b1;
      tick();
      drv_en  = 1'b0;
      mode    = HOLD;
   endtask

   task automatic read_chk(input string tag, input logic sel, input logic [M-1:0] exp);
      mode = READ;
      fph  = sel;
      #1;
      check_eq(tag, {27'd0, word}, {27'd0, exp});
   endtask

   initial begin
      reset   = 1'b1;
      mode    = HOLD;
      fph     = 1'b0;
      drv_en  = 1'b0;
      drv_val = '0;
      #2;

      // Garbage in all registers, then a single reset cycle.
      write_reg(1'b0, 5'd7);
      write_reg(1'b1, 5'd9);
      mode = RUN;
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      mode  = HOLD;
      check_eq("reset_phase", {28'd0, phase}, 32'd0);
      check_wrap("reset_wrap", 1'b0);
      read_chk("reset_rd_freq", 1'b0, 5'd0);
      read_chk("reset_rd_poff", 1'b1, 5'd0);
      mode = HOLD;

      // Write then read back both registers; bus released outside read mode.
      write_reg(1'b1, 5'd5);
      write_reg(1'b0, 5'd2);
      read_chk("rd_poff5", 1'b1, 5'd5);
      read_chk("rd_freq2", 1'b0, 5'd2);
      mode = HOLD;
      #1;
      check_eq("hiz_hold", {27'd0, word}, 32'h1f);
      check_eq("phase_after_wr", {28'd0, phase}, 32'd2);  // acc 0 + poff 5 -> 5>>1

      // Run: freq 2, poff 0 -> phase counts 1..15 then wraps to 0.
      write_reg(1'b1, 5'd0);
      check_eq("run_phase0", {28'd0, phase}, 32'd0);
      mode = RUN;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check_eq($sformatf("run_phase_%0d", k), {28'd0, phase}, 32'(k % 16));
         check_wrap($sformatf("run_wrap_%0d", k), k == 16);
      end
      check_eq("hiz_run", {27'd0, word}, 32'h1f);

      // Offset: acc 0, poff 5, freq 1 -> phase = ((k + 5) mod 32) >> 1.
      write_reg(1'b1, 5'd5);
      write_reg(1'b0, 5'd1);
      check_eq("off_phase0", {28'd0, phase}, 32'd2);
      mode = RUN;
      for (int k = 1; k <= 32; k++) begin
         tick();
         check_eq($sformatf("off_phase_%0d", k), {28'd0, phase}, 32'(((k + 5) % 32) / 2));
         check_wrap($sformatf("off_wrap_%0d", k), k == 32);
      end

      // Hold mid-run: acc 3 frozen for 2 clocks, read-back also holds acc.
      tick(); tick(); tick();
      check_eq("pre_hold", {28'd0, phase}, 32'd4);
      mode = HOLD;
      tick();
      check_eq("hold_1", {28'd0, phase}, 32'd4);
      check_wrap("hold_wrap", 1'b0);
      tick();
      check_eq("hold_2", {28'd0, phase}, 32'd4);
      read_chk("hold_rd_freq", 1'b0, 5'd1);
      tick();
      check_eq("read_holds_acc", {28'd0, phase}, 32'd4);
      mode = RUN;
      tick();
      check_eq("resume_1", {28'd0, phase}, 32'd4);  // acc 4 + 5 = 9
      tick();
      check_eq("resume_2", {28'd0, phase}, 32'd5);  // acc 5 + 5 = 10

      // Nyquist: freq 16, poff 0 from acc 5 -> acc 21, 5, 21.
      write_reg(1'b1, 5'd0);
      write_reg(1'b0, 5'd16);
      mode = RUN;
      tick();
      check_eq("nyq_1", {28'd0, phase}, 32'd10);
      check_wrap("nyq_wrap_1", 1'b0);
      tick();
      check_eq("nyq_2", {28'd0, phase}, 32'd2);
      check_wrap("nyq_wrap_2", 1'b1);
      tick();
      check_eq("nyq_3", {28'd0, phase}, 32'd10);

      // Reset mid-run at acc 20: acc 21 + freq 31 = 20 (mod 32).
      write_reg(1'b0, 5'd31);
      mode = RUN;
      tick();
      check_eq("pre_reset", {28'd0, phase}, 32'd10);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_eq("mid_reset_phase", {28'd0, phase}, 32'd0);
      check_wrap("mid_reset_wrap", 1'b0);
      read_chk("mid_reset_freq", 1'b0, 5'd0);
      read_chk("mid_reset_poff", 1'b1, 5'd0);
      mode = RUN;
      tick(); tick();
      check_eq("freq0_static", {28'd0, phase}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
